// File: rtl/pm_sequencer.sv
// rtl/pm_sequencer.sv - program memory port owner: host programming in PROG, PC and fetch in RUN
module pm_sequencer #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     prog_valid,
  input  logic [DATA_WIDTH-1:0]    prog_data,
  output logic                     prog_ready,
  input  logic                     prog_done,
  input  logic                     cpu_fetch_req,
  input  logic                     cpu_jump,
  input  logic [ADDRESS_WIDTH-1:0] cpu_jump_addr,
  output logic                     fetch_valid,
  output logic [DATA_WIDTH-1:0]    fetch_instr,
  output logic [ADDRESS_WIDTH:0]   pc,
  output logic                     halted,
  output logic                     error,
  output logic [ADDRESS_WIDTH:0]   prog_len,
  output logic [ADDRESS_WIDTH-1:0] pm_addr,
  output logic                     pm_we,
  output logic [DATA_WIDTH-1:0]    pm_wdata,
  input  logic [DATA_WIDTH-1:0]    pm_rdata
);

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_PROG = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_PROG, S_RUN, S_HALT} state_t;

  state_t                 state;
  logic [ADDRESS_WIDTH:0] wr_ptr;
  logic [ADDRESS_WIDTH:0] wr_next;
  logic [ADDRESS_WIDTH:0] pc_next;
  logic                   accept;
  logic                   jump_out;

  // wr_ptr is one bit wider than the address so a full memory shows up as the MSB.
  assign prog_ready = (state == S_PROG) && !wr_ptr[ADDRESS_WIDTH];
  assign accept     = prog_valid && prog_ready;
  assign wr_next    = wr_ptr + {{ADDRESS_WIDTH{1'b0}}, accept};
  assign pc_next    = pc + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  assign jump_out   = {1'b0, cpu_jump_addr} >= prog_len;

  assign halted   = (state == S_HALT);
  assign pm_we    = accept;
  assign pm_wdata = prog_data;
  assign pm_addr  = (state == S_PROG) ? wr_ptr[ADDRESS_WIDTH-1:0] : pc[ADDRESS_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      pc          <= '0;
      prog_len    <= '0;
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      error       <= 1'b0;
    end else begin
      fetch_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mode == MODE_PROG) begin
            state  <= S_PROG;
            wr_ptr <= '0;
            error  <= 1'b0;
          end else if (mode == MODE_RUN) begin
            state <= S_RUN;
            pc    <= '0;
          end
        end
        S_PROG: begin
          wr_ptr <= wr_next;
          // A word accepted in the closing cycle still counts toward the length.
          if (prog_done || (mode != MODE_PROG)) begin
            state    <= S_IDLE;
            prog_len <= wr_next;
          end
        end
        S_RUN: begin
          if (mode != MODE_RUN) begin
            state <= S_IDLE;
          end else if (prog_len == '0) begin
            state <= S_HALT;
          end else if (cpu_jump) begin
            pc <= {1'b0, cpu_jump_addr};
            if (jump_out) begin
              state <= S_HALT;
              error <= 1'b1;
            end
          end else if (cpu_fetch_req) begin
            fetch_instr <= pm_rdata;
            fetch_valid <= 1'b1;
            pc          <= pc_next;
            if (pc_next == prog_len) begin
              state <= S_HALT;
            end
          end
        end
        S_HALT: begin
          if (mode != MODE_RUN) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
